// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, client ids and FSM states for the memory arbiter
package mem_pkg;
  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 32;
  localparam logic CL_I = 1'b0;
  localparam logic CL_D = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; on contention grants the client not granted last
import mem_pkg::*;

module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb gnt_o = &req_i ? (last_i == CL_D ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges I-cache reads and D-cache reads/writes onto one memory port
import mem_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int D_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rdy,
  output logic              busy
);
  state_t            state_q;
  logic              last_q, owner_q, wr_q, re_q, we_q, i_ack_q, d_ack_q, busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic [1:0]        gnt_d;
  logic              d_pick_d, wr_d;

  rr_arb2 u_rr (
    .req_i ({d_re | d_we, i_req}),
    .last_i(last_q),
    .gnt_o (gnt_d)
  );

  always_comb begin
    d_pick_d = gnt_d[CL_D];
    wr_d     = d_pick_d & d_we;
  end

  // strobes and acks default low so each is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= D_FIRST != 0 ? CL_I : CL_D;
      owner_q   <= CL_I;
      wr_q      <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (mem_rdy && |gnt_d) begin
            owner_q <= d_pick_d;
            last_q  <= d_pick_d;
            wr_q    <= wr_d;
            re_q    <= ~wr_d;
            we_q    <= wr_d;
            addr_q  <= d_pick_d ? d_addr : i_addr;
            wdata_q <= d_pick_d ? d_wdata : wdata_q;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT:
          if (mem_rdy) begin
            if (!wr_q && owner_q == CL_D) d_rdata_q <= mem_rd_data;
            if (!wr_q && owner_q == CL_I) i_rdata_q <= mem_rd_data;
            i_ack_q <= owner_q == CL_I;
            d_ack_q <= owner_q == CL_D;
            state_q <= ST_RESP;
          end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
endmodule
